// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle for the shared 16->32 immediate extender.
// The "master" side is the requesters plus the result consumer; "slave" is the arbiter.
interface imm_ext_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][15:0]  req_imm;
  logic [NREQ-1:0]        req_ext_op;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_data;
  logic [IDW-1:0]         rsp_id;

  modport master (
    output req_valid, req_imm, req_ext_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_imm, req_ext_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one 16->32 immediate extender among NREQ requesters,
// with a single registered result slot on a valid/ready response channel.
module imm_ext_lane (
  input  logic [15:0] imm,
  input  logic        ext_op,
  output logic [31:0] data
);
  assign data = {{16{ext_op & imm[15]}}, imm};
endmodule

module imm_ext_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_ext_arbiter_if.slave   bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [IDW-1:0]         rr_ptr, gnt_idx, ptr_nxt;
  logic [NREQ-1:0]        grant;
  logic                   found, can_accept, fire;
  logic [IDW:0]           idx;
  logic [NREQ-1:0][31:0]  lane_data;
  logic [31:0]            sel_data;

  // Every lane extends its own immediate; the grant picks one result.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    imm_ext_lane u_lane (
      .imm    (bus.req_imm[g]),
      .ext_op (bus.req_ext_op[g]),
      .data   (lane_data[g])
    );
  end

  // Scan rr_ptr, rr_ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && idx == (IDW+1)'(i) && bus.req_valid[i]) begin
          found    = 1'b1;
          gnt_idx  = IDW'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) sel_data = sel_data | (lane_data[i] & {32{grant[i]}});
  end

  assign can_accept = (state == EMPTY) || bus.rsp_ready;
  assign fire       = can_accept && found;
  assign ptr_nxt    = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  // Gated by rst_n so no requester sees ready while the block is held in reset.
  assign bus.req_ready = (rst_n && can_accept) ? grant : '0;
  assign bus.rsp_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (fire) state_nxt = FULL;
      FULL:    if (bus.rsp_ready && !fire) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Data and id hold their last values on a drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_data <= '0;
      bus.rsp_id   <= '0;
      rr_ptr       <= '0;
    end else if (fire) begin
      bus.rsp_data <= sel_data;
      bus.rsp_id   <= gnt_idx;
      rr_ptr       <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench: a negedge monitor predicts grants from round-robin rules,
// queues expected results and checks every presented response against the queue.
module tb_imm_ext_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_ext_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  imm_ext_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0]    d;
    logic [IDW-1:0] id;
  } rsp_t;

  rsp_t            exp_q[$];
  int              errors = 0;
  int              checks = 0;
  int              m_ptr  = 0;
  bit              m_full = 1'b0;
  logic [NREQ-1:0] acc    = '0;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic op);
    if (op) return 32'($signed(imm));
    return 32'(imm);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model: sampled mid-cycle, predicts the next edge.
  always @(negedge clk) begin : mon
    int              w;
    logic [NREQ-1:0] er;
    bit              can;
    if (rst_n === 1'b1) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
      if (m_full) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: rsp_valid with no expected entry at %0t", $time);
        end else begin
          chk("rsp_data", bus.rsp_data, exp_q[0].d);
          chk("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
        end
      end
      can = !m_full || (bus.rsp_ready === 1'b1);
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      er = '0;
      if (can && w >= 0) er[w] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      if (m_full && bus.rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (er != '0) begin
        exp_q.push_back('{d: ref_ext(bus.req_imm[w], bus.req_ext_op[w]), id: IDW'(w)});
        m_ptr  = (w + 1) % NREQ;
        m_full = 1'b1;
      end else if (m_full && bus.rsp_ready) begin
        m_full = 1'b0;
      end
      acc = er;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int i, input logic [15:0] imm, input logic op);
    bus.req_valid[i]  = 1'b1;
    bus.req_imm[i]    = imm;
    bus.req_ext_op[i] = op;
  endtask

  // Asserts reset between edges with every requester valid, checks the
  // asynchronous clear, then releases after the next rising edge.
  task automatic do_reset();
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    exp_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    acc    = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.req_imm    = '0;
    bus.req_ext_op = '0;
    bus.rsp_ready  = 1'b0;
    #2;
    do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;

    // Basic extension of a positive immediate, both modes
    drive(0, 16'd123, 1'b1); step();
    chk("t1_sext_data", bus.rsp_data, 32'h0000_007B);
    chk("t1_sext_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = '0;
    drive(0, 16'd123, 1'b0); step();
    chk("t1_zext_data", bus.rsp_data, 32'h0000_007B);
    bus.req_valid = '0; step();

    // Negative immediate on requester 1
    drive(1, 16'hFF85, 1'b1); step();
    chk("t2_sext_data", bus.rsp_data, 32'hFFFF_FF85);
    chk("t2_sext_id", 32'(bus.rsp_id), 32'd1);
    drive(1, 16'hFF85, 1'b0); step();
    chk("t2_zext_data", bus.rsp_data, 32'h0000_FF85);
    bus.req_valid = '0; step();

    // Round robin from reset with both requesters held valid
    do_reset();
    bus.rsp_ready = 1'b1;
    drive(0, 16'h1111, 1'b0);
    drive(1, 16'h8002, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_rr_id", 32'(bus.rsp_id), 32'(k % 2));
      chk("t3_no_bubble", 32'(bus.rsp_valid), 32'd1);
    end

    // Backpressure for three cycles, then same-cycle refill
    held = bus.rsp_data;
    bus.rsp_ready = 1'b0;
    step(3);
    chk("t4_held_data", bus.rsp_data, held);
    chk("t4_held_id", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    step();
    chk("t4_refill_id", 32'(bus.rsp_id), 32'd0);
    chk("t4_refill_valid", 32'(bus.rsp_valid), 32'd1);

    // Drain to empty; pointer must survive idle cycles
    bus.req_valid = '0;
    step();
    chk("t5_drained", 32'(bus.rsp_valid), 32'd0);
    step(3);
    bus.req_valid = '1;
    step();
    chk("t5_next_id", 32'(bus.rsp_id), 32'd1);
    bus.req_valid = '0; step();

    // Reset while a sign-extended negative result is held
    bus.rsp_ready = 1'b0;
    drive(1, 16'hFF85, 1'b1);
    step();
    chk("t6_full_data", bus.rsp_data, 32'hFFFF_FF85);
    bus.req_valid = '0;
    step();
    do_reset();
    bus.rsp_ready = 1'b1;
    step();
    chk("t6_first_id", 32'(bus.rsp_id), 32'd0);
    chk("t6_first_valid", 32'(bus.rsp_valid), 32'd1);

    // Randomized traffic; requesters hold their request until accepted
    bus.req_valid = '0;
    step();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          bus.req_valid[i]  = ($urandom_range(0, 3) != 0);
          bus.req_imm[i]    = 16'($urandom);
          bus.req_ext_op[i] = 1'($urandom);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step(3);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
Shares one 16-to-32 immediate extension unit among NREQ requesters, for example the branch-offset path and the ALU-immediate path of the processor.
- Each requester presents a 16-bit immediate and an extension mode over a valid/ready handshake.
- A round-robin scheduler grants one requester per cycle.
- The extended 32-bit result is registered and returned with the requester ID over a valid/ready response channel.

Parameters:
NREQ, 2, number of requesters; legal values 2..4.
IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NREQ  bit i high means requester i presents a request.
req_imm  input  16*NREQ  immediate for requester i, in bits [16i+15:16i].
req_ext_op  input  NREQ  bit i: 1 = sign extend, 0 = zero extend.
req_ready  output  NREQ  bit i high means requester i's request is accepted this cycle.
rsp_valid  output  1  a result is held in the output register.
rsp_ready  input  1  the consumer accepts the result this cycle.
rsp_data  output  32  extended result.
rsp_id  output  IDW  index of the requester that produced rsp_data.

Behaviour:
- Reset: the asynchronous assertion of rst_n low clears the following immediately, regardless of clk:
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 (combinational consequence).
- Reset mid-transfer: an in-flight result is discarded and is never presented afterwards.
- Reset release: operation may begin on the first rising edge after rst_n returns high.
- Extension function:
  - ext_op=1: out = {{16{imm[15]}}, imm}.
  - ext_op=0: out = {16'b0, imm}.
- Output register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Accept condition: can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NREQ.
  - At most one grant per cycle.
- req_ready[i] = can_accept && grant[i]. It may depend combinationally on req_valid and rsp_ready.
- Handshake on requester i: req_valid[i] && req_ready[i] at the rising edge. On that edge:
  - rsp_data <= ext(req_imm[i], req_ext_op[i]).
  - rsp_id <= i.
  - rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Drain without refill: rsp_valid && rsp_ready with no request handshake in the same cycle gives rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Simultaneous drain and refill: the new result is loaded, rsp_valid stays 1. There is no bubble, so throughput is 1 result per cycle.
- Latency: exactly 1 cycle from the request handshake to rsp_valid.
- Backpressure: while FULL and rsp_ready=0:
  - all req_ready=0;
  - rsp_data, rsp_id and rsp_valid are held stable;
  - rr_ptr is unchanged.
- Requester protocol: a requester must hold req_valid, req_imm and req_ext_op stable until it sees req_ready. The block does not depend on it doing so.
- No valid requests: no grant and rr_ptr is unchanged.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0,...
- A single continuously valid requester is granted every cycle.

Test Plan:
1. Basic extension: NREQ=2, req 0 imm=16'd123, ext_op=1, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=0x0000007B, rsp_id=0. Repeat with ext_op=0 -> same data.
2. Negative immediate: req 1 imm=16'hFF85 (-123):
   - ext_op=1 -> rsp_data=0xFFFFFF85, rsp_id=1.
   - ext_op=0 -> rsp_data=0x0000FF85.
3. Round robin: both requesters held valid from reset, rsp_ready=1 -> grant/rsp_id sequence 0,1,0,1 on consecutive cycles, one result per cycle with no bubbles.
4. Backpressure: result FULL, rsp_ready=0 for 3 cycles with both requesters valid:
   - req_ready=00 throughout and rsp_data held.
   - Raising rsp_ready -> same-cycle refill; next rsp_id is the requester after the held one.
5. Drain to empty: a single request, then rsp_ready=1 with no further requests -> rsp_valid falls after one cycle and rr_ptr is unchanged on the following idle cycles.
6. Reset mid-operation: FULL with rsp_data=0xFFFFFF85, assert rst_n low between clock edges -> rsp_valid=0, rsp_data=0, rsp_id=0 immediately. After release with both requesters valid, the first grant goes to requester 0.
